// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts one bubble per load-use hazard, squashes on FLUSH, counts stalls.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      IF_ID_RS1,
  input  logic [4:0]      IF_ID_RS2,
  input  logic [4:0]      IF_ID_RD,
  input  logic [XLEN-1:0] ID_RD1,
  input  logic [XLEN-1:0] ID_RD2,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [XLEN-1:0] ID_PC,
  input  logic            ID_VALID,
  input  logic            ID_RegWrite,
  input  logic            ID_MemRead,
  input  logic            ID_MemWrite,
  input  logic            ID_MemtoReg,
  input  logic            ID_ALUSrc,
  input  logic [1:0]      ID_ALUOp,
  input  logic            FLUSH,
  output logic [4:0]      ID_EX_RS1,
  output logic [4:0]      ID_EX_RS2,
  output logic [4:0]      ID_EX_RD,
  output logic [XLEN-1:0] ID_EX_RD1,
  output logic [XLEN-1:0] ID_EX_RD2,
  output logic [XLEN-1:0] ID_EX_IMM,
  output logic [XLEN-1:0] ID_EX_PC,
  output logic            ID_EX_VALID,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_ALUSrc,
  output logic [1:0]      ID_EX_ALUOp,
  output logic            PC_Write,
  output logic            IF_ID_Write,
  output logic            STALL,
  output logic [15:0]     STALL_CNT
);

  logic hz;
  logic rs_match;
  logic bubble;

  always_comb begin
    rs_match = (ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2);
    hz = ID_EX_VALID && ID_EX_MemRead && (ID_EX_RD != 5'd0)
         && ID_VALID && rs_match;
  end

  assign STALL       = hz;
  assign PC_Write    = ~hz;
  assign IF_ID_Write = ~hz;
  assign bubble      = FLUSH | hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_RS1      <= '0;
      ID_EX_RS2      <= '0;
      ID_EX_RD       <= '0;
      ID_EX_RD1      <= '0;
      ID_EX_RD2      <= '0;
      ID_EX_IMM      <= '0;
      ID_EX_PC       <= '0;
      ID_EX_VALID    <= 1'b0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_ALUOp    <= 2'b00;
    end else if (bubble) begin
      ID_EX_RS1      <= '0;
      ID_EX_RS2      <= '0;
      ID_EX_RD       <= '0;
      ID_EX_RD1      <= '0;
      ID_EX_RD2      <= '0;
      ID_EX_IMM      <= '0;
      ID_EX_PC       <= '0;
      ID_EX_VALID    <= 1'b0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_ALUOp    <= 2'b00;
    end else begin
      ID_EX_RS1      <= IF_ID_RS1;
      ID_EX_RS2      <= IF_ID_RS2;
      ID_EX_RD       <= IF_ID_RD;
      ID_EX_RD1      <= ID_RD1;
      ID_EX_RD2      <= ID_RD2;
      ID_EX_IMM      <= ID_IMM;
      ID_EX_PC       <= ID_PC;
      ID_EX_VALID    <= ID_VALID;
      // invalid slots must never write registers or memory
      ID_EX_RegWrite <= ID_RegWrite & ID_VALID;
      ID_EX_MemRead  <= ID_MemRead  & ID_VALID;
      ID_EX_MemWrite <= ID_MemWrite & ID_VALID;
      ID_EX_MemtoReg <= ID_MemtoReg & ID_VALID;
      ID_EX_ALUSrc   <= ID_ALUSrc   & ID_VALID;
      ID_EX_ALUOp    <= ID_ALUOp    & {2{ID_VALID}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      STALL_CNT <= 16'h0000;
    end else if (hz && !FLUSH && STALL_CNT != 16'hFFFF) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: data path width.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have inputs IF_ID_RS1, IF_ID_RS2, IF_ID_RD, 5 bits each: decoded register addresses of the instruction in ID.
REQ-005 SHALL have inputs ID_RD1, ID_RD2, ID_IMM, ID_PC, XLEN bits each: register-file read data, immediate, PC from ID.
REQ-006 SHALL have input ID_VALID, 1 bit: ID holds a real instruction.
REQ-007 SHALL have inputs ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc (1 bit each), ID_ALUOp (2 bits): decoded controls.
REQ-008 SHALL have input FLUSH, 1 bit: branch/jump taken in EX; squash the instruction entering ID/EX.
REQ-009 SHALL have outputs ID_EX_RS1, ID_EX_RS2, ID_EX_RD (5 bits), ID_EX_RD1, ID_EX_RD2, ID_EX_IMM, ID_EX_PC (XLEN bits), ID_EX_VALID and the six ID_EX_<control> copies (same widths as inputs): registered stage contents feeding EX and the forwarding logic.
REQ-010 SHALL have outputs PC_Write, IF_ID_Write, 1 bit each: 0 freezes PC and IF/ID register.
REQ-011 SHALL have output STALL, 1 bit, and STALL_CNT, 16 bits: load-use stall indicator and saturating stall count.

Function
REQ-012 SHALL assert load-use hazard HZ combinationally when ID_EX_VALID=1, ID_EX_MemRead=1, ID_EX_RD!=0, ID_VALID=1, and ID_EX_RD equals IF_ID_RS1 or IF_ID_RS2.
REQ-013 SHALL drive STALL=HZ and PC_Write=IF_ID_Write=~HZ, all combinational.
REQ-014 SHALL, on a clock edge with FLUSH=1, load a bubble: ID_EX_VALID=0, all six control outputs 0, RS1/RS2/RD=0; data fields don't-care but SHALL be loaded with 0.
REQ-015 SHALL, on a clock edge with FLUSH=0 and HZ=1, load a bubble as in REQ-014 (stall inserts exactly one bubble per hazard cycle).
REQ-016 SHALL, on a clock edge with FLUSH=0 and HZ=0, capture all ID inputs into the matching ID_EX outputs, ID_EX_VALID<=ID_VALID.
REQ-017 SHALL, when captured ID_VALID=0, also force captured control outputs to 0 so an invalid slot never writes registers or memory.
REQ-018 SHALL give FLUSH priority over HZ when both are asserted; PC_Write/IF_ID_Write still follow REQ-013.
REQ-019 SHALL have latency exactly one cycle from ID inputs to ID_EX outputs; a load-use pair costs exactly one stall cycle (HZ deasserts the cycle after the bubble is loaded because ID_EX_VALID=0).
REQ-020 SHALL increment STALL_CNT by 1 on each clock edge where HZ=1 and FLUSH=0, saturating at 16'hFFFF (no wrap).
REQ-021 SHALL treat rd=x0 loads as non-hazards (REQ-012 condition ID_EX_RD!=0).

Reset
REQ-022 SHALL, while rst=1, asynchronously clear every registered output (ID_EX_* fields, ID_EX_VALID, controls, STALL_CNT) to 0.
REQ-023 SHALL, during and immediately after reset, present PC_Write=1, IF_ID_Write=1, STALL=0 (follows from ID_EX_VALID=0).
REQ-024 SHALL, if rst asserts mid-stall, abandon the stall immediately; first post-reset edge behaves per REQ-016.

Verification
REQ-025 Bench: load x5 (MemRead=1, RD=5) captured, then ID instruction with RS1=5 -> STALL=1, PC_Write=0, next edge ID_EX_VALID=0 and controls 0, following cycle STALL=0 and dependent instruction captured with RS1=5.
REQ-026 Bench: load to RD=0, then ID RS2=0 -> STALL=0, no bubble, STALL_CNT unchanged.
REQ-027 Bench: FLUSH=1 with HZ=1 same cycle -> bubble loaded, STALL_CNT not incremented, PC_Write=0 that cycle.
REQ-028 Bench: non-load ALU op RD=7 followed by RS1=7 -> no stall; ID_EX_RS1=7, ID_EX_RegWrite propagates one cycle later (forwarding handles it).
REQ-029 Bench: preload STALL_CNT to 16'hFFFE via 2 forced-hazard cycles after 65534 hazards (or force) -> reads 16'hFFFF and stays there on further hazards.
REQ-030 Bench: assert rst asynchronously between edges while ID_EX_MemRead=1 and STALL=1 -> outputs clear without a clock edge, STALL=0, PC_Write=1 immediately.
